servo_pwm_capture: RTL and testbench
====================================

# servo_pwm_capture

Measures an incoming hobby-servo PWM signal (nominally 50 Hz, 1000–2000 us high time) and reports pulse width and frame period in microseconds. It is the receive-side counterpart of the servo PWM generators: it lets the board read an RC receiver or loop back its own servo outputs for self-test. Frames that fall outside limits are rejected, and a missing signal is flagged.

## Interface
- CLK_HZ, 50_000_000, system clock frequency; DIV = CLK_HZ/1_000_000 clocks per microsecond (integer, >= 2)
- MIN_US, 500, smallest accepted high time
- MAX_US, 2500, largest accepted high time
- PERIOD_MIN_US, 3000, smallest accepted rise-to-rise period
- PERIOD_MAX_US, 25000, largest accepted period
- TIMEOUT_US, 30000, time since last rise after which the signal is declared lost; must exceed PERIOD_MAX_US and be < 65535

- clk  in  1  system clock, one clock domain
- rst_n  in  1  asynchronous active-low reset
- pwm_in  in  1  asynchronous PWM input
- width_us  out  16  last accepted high time in us
- period_us  out  16  last accepted period in us
- width_valid  out  1  one-cycle strobe when width_us and period_us update
- glitch_err  out  1  one-cycle strobe when a completed frame is rejected
- signal_lost  out  1  level, set when no valid frame completes within the timeout

## Operation
- pwm_in passes through a 2-flop synchronizer and then a delay flop. All three flops reset to 1, so a pin that is high at reset release does not produce a false rise.
- rise = sync & ~prev; fall = ~sync & prev. Edges on the synchronized signal strictly alternate.
- Timebase:
  - Prescaler counts 0..DIV-1.
  - elapsed_us increments when the prescaler is at DIV-1.
  - Both are cleared on every rise.
  - At n clocks after the rise cycle, elapsed_us = floor(n/DIV).
- States: WAIT_RISE, HIGH, LOW.
  - WAIT_RISE: on rise, go to HIGH and clear the timebase. A fall is ignored. No outputs are produced.
  - HIGH: on fall, latch high_us <= elapsed_us and go to LOW.
  - LOW: on rise, a frame is complete. Evaluate high_us and elapsed_us (this value is the period). Clear the timebase and go to HIGH; the new frame starts at this rise.
- Frame acceptance: MIN_US <= high_us <= MAX_US and PERIOD_MIN_US <= period <= PERIOD_MAX_US.
  - Accepted: width_us <= high_us, period_us <= period, width_valid = 1 for one cycle, signal_lost <= 0.
  - Rejected: glitch_err = 1 for one cycle. width_us, period_us and signal_lost hold.
- Timeout:
  - Applies in HIGH or LOW when elapsed_us reaches TIMEOUT_US.
  - signal_lost <= 1 and state goes to WAIT_RISE.
  - width_us and period_us hold their last values. glitch_err does not pulse.
  - In WAIT_RISE the timebase stops, so signal_lost stays set until an accepted frame completes.
- Arithmetic: all us counters are 16-bit unsigned. Overflow cannot occur because the timeout fires first.

## Timing
- Reset values: width_us = 0, period_us = 0, width_valid = 0, glitch_err = 0, signal_lost = 1, state = WAIT_RISE, synchronizer flops = 1, counters = 0.
- Pin-to-edge latency is a fixed 2 clocks. It is identical for both edges, so measured durations are unaffected.
- Result latency: width_valid, width_us and period_us update in the same cycle. This is the registered cycle after rise is detected for the frame that is ending.
- Measurement resolution is 1 us with truncation. An edge-to-edge interval of n clocks reports floor(n/DIV).
- Minimum frame is 2 detected edges after the first rise. The first rise after reset or after a timeout only arms the block.
- If reset is asserted mid-frame, all state is cleared immediately. The partial frame produces no strobe.
- Pulses shorter than 2 clocks may be missed by the synchronizer. This is accepted behaviour.

## Test plan
- Reset, then drive pwm_in with 1500 us high / 20000 us period for 3 frames → first strobe at the 2nd rise, width_us = 1500, period_us = 20000, signal_lost falls to 0 on that strobe, one strobe per subsequent rise.
- Hold pwm_in high through reset release, then drive a normal 1000/20000 waveform → no strobe or glitch_err until the first full frame after a genuine rise, then width_us = 1000.
- Drive a 300 us high pulse within a 20000 us frame after a valid frame → glitch_err single pulse, width_us stays at the prior value, width_valid stays 0.
- Drive a valid frame, then hold pwm_in low → signal_lost = 1 exactly 30000 us after the last rise, state WAIT_RISE; the next two valid frames clear it on the 2nd rise.
- Drive 2000/3000 us (period minimum) and 2500/25000 us (limits) → both accepted with exact values. Drive 2501 us high or a 25001 us period → glitch_err.
- Assert rst_n mid-HIGH → outputs return to reset values asynchronously; no strobe follows for the partial frame.

Source files
------------

// File: rtl/servo_pwm_capture.sv
// -----------------------------------------------------------------------------
// servo_pwm_capture
//
// Measures a hobby-servo PWM input. It reports the high time and the
// rise-to-rise period in microseconds. A frame is the interval between two
// rises. It is checked against width and period limits when its closing rise
// arrives. If no frame completes within TIMEOUT_US of the last rise, the input
// is flagged as lost.
//
// Ports
//   clk          system clock (CLK_HZ)
//   rst_n        asynchronous active-low reset
//   pwm_in       asynchronous PWM input pin
//   width_us     last accepted high time, microseconds
//   period_us    last accepted rise-to-rise period, microseconds
//   width_valid  one-cycle strobe when width_us/period_us update
//   glitch_err   one-cycle strobe when a completed frame is rejected
//   signal_lost  level; set on timeout, cleared by the next accepted frame
// -----------------------------------------------------------------------------
module servo_pwm_capture #(
    parameter int unsigned CLK_HZ        = 50_000_000,
    parameter int unsigned MIN_US        = 500,
    parameter int unsigned MAX_US        = 2500,
    parameter int unsigned PERIOD_MIN_US = 3000,
    parameter int unsigned PERIOD_MAX_US = 25000,
    parameter int unsigned TIMEOUT_US    = 30000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pwm_in,
    output logic [15:0] width_us,
    output logic [15:0] period_us,
    output logic        width_valid,
    output logic        glitch_err,
    output logic        signal_lost
);

    localparam int unsigned DIV   = CLK_HZ / 1_000_000;
    localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(DIV - 1);
    localparam logic [15:0]      MIN_C     = 16'(MIN_US);
    localparam logic [15:0]      MAX_C     = 16'(MAX_US);
    localparam logic [15:0]      PMIN_C    = 16'(PERIOD_MIN_US);
    localparam logic [15:0]      PMAX_C    = 16'(PERIOD_MAX_US);
    localparam logic [15:0]      TIMEOUT_C = 16'(TIMEOUT_US);

    typedef enum logic [1:0] {
        WAIT_RISE,
        HIGH,
        LOW
    } state_t;

    // Synchronizer and edge-detect delay flop
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    // Control and timebase
    state_t           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [15:0]      elapsed_q, elapsed_d;
    logic [15:0]      high_q, high_d;

    // Registered outputs
    logic [15:0] width_q, width_d;
    logic [15:0] period_q, period_d;
    logic        width_valid_q, width_valid_d;
    logic        glitch_err_q, glitch_err_d;
    logic        signal_lost_q, signal_lost_d;

    logic             rise;
    logic             fall;
    logic             tick;
    logic [PRE_W-1:0] pre_inc;
    logic [15:0]      elapsed_inc;

    function automatic logic frame_ok(input logic [15:0] hi, input logic [15:0] per);
        return (hi >= MIN_C) && (hi <= MAX_C) && (per >= PMIN_C) && (per <= PMAX_C);
    endfunction

    assign rise = sync2_q & ~prev_q;
    assign fall = ~sync2_q & prev_q;
    assign tick = (pre_q == PRE_LAST);

    // The timebase is cleared on the rise cycle, so the registered count lags
    // the number of elapsed clocks by one. Sampling the incremented value makes
    // an interval of n clocks between detected edges read as floor(n/DIV).
    assign pre_inc     = tick ? '0 : pre_q + PRE_W'(1);
    assign elapsed_inc = elapsed_q + {15'd0, tick};

    always_comb begin
        sync1_d       = pwm_in;
        sync2_d       = sync1_q;
        prev_d        = sync2_q;
        state_d       = state_q;
        pre_d         = pre_q;
        elapsed_d     = elapsed_q;
        high_d        = high_q;
        width_d       = width_q;
        period_d      = period_q;
        width_valid_d = 1'b0;
        glitch_err_d  = 1'b0;
        signal_lost_d = signal_lost_q;

        case (state_q)
            WAIT_RISE: begin
                // Timebase frozen here; the first rise only arms the block.
                if (rise) begin
                    state_d   = HIGH;
                    pre_d     = '0;
                    elapsed_d = '0;
                end
            end

            HIGH: begin
                pre_d     = pre_inc;
                elapsed_d = elapsed_inc;
                if (elapsed_inc == TIMEOUT_C) begin
                    signal_lost_d = 1'b1;
                    state_d       = WAIT_RISE;
                end else if (fall) begin
                    high_d  = elapsed_inc;
                    state_d = LOW;
                end
            end

            LOW: begin
                pre_d     = pre_inc;
                elapsed_d = elapsed_inc;
                if (elapsed_inc == TIMEOUT_C) begin
                    signal_lost_d = 1'b1;
                    state_d       = WAIT_RISE;
                end else if (rise) begin
                    // Closing rise of this frame is also the opening rise of
                    // the next one.
                    if (frame_ok(high_q, elapsed_inc)) begin
                        width_d       = high_q;
                        period_d      = elapsed_inc;
                        width_valid_d = 1'b1;
                        signal_lost_d = 1'b0;
                    end else begin
                        glitch_err_d = 1'b1;
                    end
                    pre_d     = '0;
                    elapsed_d = '0;
                    state_d   = HIGH;
                end
            end

            default: begin
                state_d = WAIT_RISE;
            end
        endcase
    end

    // Synchronizer flops reset high so a pin already high at reset release
    // is not mistaken for a rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            prev_q        <= 1'b1;
            state_q       <= WAIT_RISE;
            pre_q         <= '0;
            elapsed_q     <= '0;
            high_q        <= '0;
            width_q       <= '0;
            period_q      <= '0;
            width_valid_q <= 1'b0;
            glitch_err_q  <= 1'b0;
            signal_lost_q <= 1'b1;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            prev_q        <= prev_d;
            state_q       <= state_d;
            pre_q         <= pre_d;
            elapsed_q     <= elapsed_d;
            high_q        <= high_d;
            width_q       <= width_d;
            period_q      <= period_d;
            width_valid_q <= width_valid_d;
            glitch_err_q  <= glitch_err_d;
            signal_lost_q <= signal_lost_d;
        end
    end

    assign width_us    = width_q;
    assign period_us   = period_q;
    assign width_valid = width_valid_q;
    assign glitch_err  = glitch_err_q;
    assign signal_lost = signal_lost_q;

endmodule

// File: tb/tb_servo_pwm_capture.sv
// -----------------------------------------------------------------------------
// tb_servo_pwm_capture
//
// Directed bench for servo_pwm_capture. The clock is 2 MHz (DIV = 2), and all
// microsecond limits are scaled down tenfold so that frames stay short:
//   width 50..250 us, period 300..2500 us, timeout 3000 us.
// Waveforms are built from exact multiples of DIV clocks, so every interval
// measures to the exact microsecond value driven.
// -----------------------------------------------------------------------------
module tb_servo_pwm_capture;

    localparam int DIV = 2;

    logic        clk;
    logic        rst_n;
    logic        pwm_in;
    logic [15:0] width_us;
    logic [15:0] period_us;
    logic        width_valid;
    logic        glitch_err;
    logic        signal_lost;

    int n_cmp = 0;
    int n_err = 0;
    int wv_cnt = 0;
    int ge_cnt = 0;
    int wv0;
    int ge0;

    servo_pwm_capture #(
        .CLK_HZ       (2_000_000),
        .MIN_US       (50),
        .MAX_US       (250),
        .PERIOD_MIN_US(300),
        .PERIOD_MAX_US(2500),
        .TIMEOUT_US   (3000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwm_in     (pwm_in),
        .width_us   (width_us),
        .period_us  (period_us),
        .width_valid(width_valid),
        .glitch_err (glitch_err),
        .signal_lost(signal_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count strobe cycles; a strobe held for two cycles counts twice.
    always @(negedge clk) begin
        if (width_valid === 1'b1) wv_cnt++;
        if (glitch_err === 1'b1) ge_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive a level for a whole number of microseconds; starts and ends 1 time
    // unit after a rising clock edge.
    task automatic hold(input logic lvl, input int us);
        pwm_in = lvl;
        repeat (us * DIV) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_width", 32'(width_us), 32'd0);
        check("rst_period", 32'(period_us), 32'd0);
        check("rst_wv", 32'(width_valid), 32'd0);
        check("rst_ge", 32'(glitch_err), 32'd0);
        check("rst_lost", 32'(signal_lost), 32'd1);
        rst_n = 1'b1;
        hold(1'b0, 10);

        // Three 150/2000 frames; the first rise only arms.
        wv0 = wv_cnt;
        ge0 = ge_cnt;
        hold(1'b1, 150);
        hold(1'b0, 1850);
        check("t1_arm_no_strobe", 32'(wv_cnt - wv0), 32'd0);
        check("t1_lost_still_set", 32'(signal_lost), 32'd1);
        hold(1'b1, 5);
        check("t1_first_strobe", 32'(wv_cnt - wv0), 32'd1);
        check("t1_width", 32'(width_us), 32'd150);
        check("t1_period", 32'(period_us), 32'd2000);
        check("t1_lost_clear", 32'(signal_lost), 32'd0);
        hold(1'b1, 145);
        hold(1'b0, 1850);
        hold(1'b1, 150);
        hold(1'b0, 1850);
        hold(1'b1, 5);
        check("t1_strobe_count", 32'(wv_cnt - wv0), 32'd3);
        check("t1_no_glitch", 32'(ge_cnt - ge0), 32'd0);
        check("t1_width_again", 32'(width_us), 32'd150);

        // Reset mid-HIGH: outputs clear without waiting for a clock edge.
        rst_n = 1'b0;
        #2;
        check("mid_rst_width", 32'(width_us), 32'd0);
        check("mid_rst_period", 32'(period_us), 32'd0);
        check("mid_rst_lost", 32'(signal_lost), 32'd1);
        check("mid_rst_wv", 32'(width_valid), 32'd0);

        // Pin held high through reset release, then a 100/2000 waveform.
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wv0 = wv_cnt;
        ge0 = ge_cnt;
        hold(1'b1, 95);
        hold(1'b0, 1905);
        check("t2_partial_no_strobe", 32'(wv_cnt - wv0), 32'd0);
        check("t2_partial_no_glitch", 32'(ge_cnt - ge0), 32'd0);
        hold(1'b1, 100);
        hold(1'b0, 1900);
        check("t2_arm_no_strobe", 32'(wv_cnt - wv0), 32'd0);
        hold(1'b1, 5);
        check("t2_strobe", 32'(wv_cnt - wv0), 32'd1);
        check("t2_width", 32'(width_us), 32'd100);
        check("t2_period", 32'(period_us), 32'd2000);
        check("t2_lost_clear", 32'(signal_lost), 32'd0);

        // Valid 100/2000 frame, then a 30 us runt pulse.
        wv0 = wv_cnt;
        ge0 = ge_cnt;
        hold(1'b1, 95);
        hold(1'b0, 1900);
        hold(1'b1, 30);
        hold(1'b0, 1970);
        hold(1'b1, 5);
        check("t3_valid_strobe", 32'(wv_cnt - wv0), 32'd1);
        check("t3_glitch", 32'(ge_cnt - ge0), 32'd1);
        check("t3_width_held", 32'(width_us), 32'd100);
        check("t3_period_held", 32'(period_us), 32'd2000);

        // Valid frame, then the pin stays low until the timeout.
        wv0 = wv_cnt;
        ge0 = ge_cnt;
        hold(1'b1, 95);
        hold(1'b0, 1900);
        hold(1'b1, 100);
        hold(1'b0, 2895);
        check("t4_before_timeout", 32'(signal_lost), 32'd0);
        check("t4_valid_strobe", 32'(wv_cnt - wv0), 32'd1);
        hold(1'b0, 10);
        check("t4_after_timeout", 32'(signal_lost), 32'd1);
        check("t4_no_glitch", 32'(ge_cnt - ge0), 32'd0);
        check("t4_width_held", 32'(width_us), 32'd100);
        check("t4_period_held", 32'(period_us), 32'd2000);
        hold(1'b1, 150);
        hold(1'b0, 1850);
        check("t4_rearm_lost", 32'(signal_lost), 32'd1);
        check("t4_rearm_no_strobe", 32'(wv_cnt - wv0), 32'd1);
        hold(1'b1, 5);
        check("t4_recover_strobe", 32'(wv_cnt - wv0), 32'd2);
        check("t4_recover_lost", 32'(signal_lost), 32'd0);
        check("t4_recover_width", 32'(width_us), 32'd150);

        // Limits: 200/300 and 250/2500 accepted, 251 us high and a 2501 us
        // period rejected, 50 us high accepted.
        wv0 = wv_cnt;
        ge0 = ge_cnt;
        hold(1'b1, 195);
        hold(1'b0, 100);
        hold(1'b1, 5);
        check("t5_pmin_strobe", 32'(wv_cnt - wv0), 32'd1);
        check("t5_pmin_width", 32'(width_us), 32'd200);
        check("t5_pmin_period", 32'(period_us), 32'd300);
        hold(1'b1, 245);
        hold(1'b0, 2250);
        hold(1'b1, 5);
        check("t5_max_strobe", 32'(wv_cnt - wv0), 32'd2);
        check("t5_max_width", 32'(width_us), 32'd250);
        check("t5_max_period", 32'(period_us), 32'd2500);
        hold(1'b1, 246);
        hold(1'b0, 1749);
        hold(1'b1, 5);
        check("t5_wide_glitch", 32'(ge_cnt - ge0), 32'd1);
        check("t5_wide_width_held", 32'(width_us), 32'd250);
        hold(1'b1, 145);
        hold(1'b0, 2351);
        hold(1'b1, 5);
        check("t5_long_glitch", 32'(ge_cnt - ge0), 32'd2);
        check("t5_long_period_held", 32'(period_us), 32'd2500);
        check("t5_no_extra_strobe", 32'(wv_cnt - wv0), 32'd2);
        hold(1'b1, 45);
        hold(1'b0, 1950);
        hold(1'b1, 5);
        check("t5_min_strobe", 32'(wv_cnt - wv0), 32'd3);
        check("t5_min_width", 32'(width_us), 32'd50);
        check("t5_min_period", 32'(period_us), 32'd2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
